// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one 8N1 UART transmitter among N byte requesters,
// with a per-requester lock so multi-byte messages go out without interleaving.
//
// state     | meaning
// IDLE      | no frame in flight; a winner is accepted when en and tx ready
// ISSUE     | valid/en held to the transmitter until it drops ready
// WAIT_DONE | frame on the line; waiting for the transmitter to raise ready
module uart_tx_arbiter #(
    parameter int N = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic [N-1:0]     i_req_valid,
    input  logic [8*N-1:0]   i_req_data,
    input  logic [N-1:0]     i_req_last,
    output logic [N-1:0]     o_req_ready,
    output logic             o_tx_en,
    output logic             o_tx_valid,
    output logic [7:0]       o_tx_in,
    input  logic             i_tx_ready,
    output logic [N-1:0]     o_grant,
    output logic             o_busy
);

    localparam int PW  = $clog2(N);
    localparam int PW1 = PW + 1;
    localparam logic [PW1-1:0] N_W      = PW1'(N);
    localparam logic [PW-1:0]  LAST_IDX = PW'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_DONE
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [PW-1:0]     r_ptr;
    logic              r_lock;
    logic [PW-1:0]     r_owner;
    logic              r_tx_valid;
    logic              r_tx_en;
    logic [7:0]        r_tx_in;
    logic [N-1:0]      r_grant;

    logic [PW-1:0]     w_rot_idx [N];
    logic              w_win_found;
    logic [PW-1:0]     w_win_idx;
    logic [N-1:0]      w_win_onehot;
    logic [7:0]        w_win_data;
    logic              w_accept;

    // Scan order ptr, ptr+1, ... wrapped at N (N need not be a power of two).
    for (genvar g = 0; g < N; g++) begin : g_rot
        logic [PW1-1:0] w_sum;
        assign w_sum        = {1'b0, r_ptr} + PW1'(g);
        assign w_rot_idx[g] = (w_sum >= N_W) ? PW'(w_sum - N_W) : PW'(w_sum);
    end

    always_comb begin
        w_win_found = 1'b0;
        w_win_idx   = '0;
        if (r_lock) begin
            w_win_found = i_req_valid[r_owner];
            w_win_idx   = r_owner;
        end else begin
            // Walk backwards so the closest eligible index to ptr is the last write.
            for (int k = N - 1; k >= 0; k--) begin
                if (i_req_valid[w_rot_idx[k]]) begin
                    w_win_found = 1'b1;
                    w_win_idx   = w_rot_idx[k];
                end
            end
        end
    end

    assign w_win_onehot = N'(1) << w_win_idx;
    assign w_win_data   = i_req_data[8*w_win_idx +: 8];
    assign w_accept     = (r_state == S_IDLE) & i_en & i_tx_ready & w_win_found;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:      if (w_accept)    w_state_nxt = S_ISSUE;
            S_ISSUE:     if (!i_tx_ready) w_state_nxt = S_WAIT_DONE;
            S_WAIT_DONE: if (i_tx_ready)  w_state_nxt = S_IDLE;
            default:                      w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_ptr      <= '0;
            r_lock     <= 1'b0;
            r_owner    <= '0;
            r_tx_valid <= 1'b0;
            r_tx_en    <= 1'b0;
            r_tx_in    <= '0;
            r_grant    <= '0;
        end else begin
            if (w_accept) begin
                r_tx_in    <= w_win_data;
                r_tx_valid <= 1'b1;
                r_tx_en    <= 1'b1;
                r_grant    <= w_win_onehot;
                if (i_req_last[w_win_idx]) begin
                    r_lock <= 1'b0;
                    r_ptr  <= (w_win_idx == LAST_IDX) ? '0 : w_win_idx + 1'b1;
                end else begin
                    r_lock  <= 1'b1;
                    r_owner <= w_win_idx;
                end
            end
            if ((r_state == S_ISSUE) && !i_tx_ready) begin
                r_tx_valid <= 1'b0;
                r_tx_en    <= 1'b0;
            end
            // A locked owner keeps its grant across the idle gap between bytes.
            if ((r_state == S_WAIT_DONE) && i_tx_ready && !r_lock) begin
                r_grant <= '0;
            end
        end
    end

    assign o_req_ready = w_accept ? w_win_onehot : '0;
    assign o_tx_valid  = r_tx_valid;
    assign o_tx_en     = r_tx_en;
    assign o_tx_in     = r_tx_in;
    assign o_grant     = r_grant;
    assign o_busy      = (r_state != S_IDLE) | r_lock;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: behavioural 8N1 transmitter and line receiver, a
// frame-timeline model of the arbiter checked every cycle, and directed scenarios.
module tb_uart_tx_arbiter;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           en;
    logic [N-1:0]   req_valid;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   req_last;
    logic [N-1:0]   req_ready;
    logic           tx_en;
    logic           tx_valid;
    logic [7:0]     tx_in;
    logic           tx_ready = 1'b1;
    logic [N-1:0]   grant;
    logic           busy;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.N(N)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_en       (en),
        .i_req_valid(req_valid),
        .i_req_data (req_data),
        .i_req_last (req_last),
        .o_req_ready(req_ready),
        .o_tx_en    (tx_en),
        .o_tx_valid (tx_valid),
        .o_tx_in    (tx_in),
        .i_tx_ready (tx_ready),
        .o_grant    (grant),
        .o_busy     (busy)
    );

    int cmp_cnt = 0;
    int err_cnt = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Transmitter: no reset; accepts on valid&en while ready, start bit one edge later.
    logic       line = 1'b1;
    int         tx_cnt = 0;
    logic [7:0] tx_sh = 8'h00;
    int         t_rdy = 0;

    always @(posedge clk) begin
        if (tx_cnt == 0) begin
            if (tx_ready && tx_valid === 1'b1 && tx_en === 1'b1) begin
                tx_ready <= 1'b0;
                tx_sh    <= tx_in;
                tx_cnt   <= 1;
            end
        end else begin
            tx_cnt <= tx_cnt + 1;
            if (tx_cnt == 1) line <= 1'b0;
            else if (tx_cnt <= 9) line <= tx_sh[tx_cnt-2];
            else if (tx_cnt == 10) line <= 1'b1;
            else begin
                tx_ready <= 1'b1;
                tx_cnt   <= 0;
                t_rdy    <= cyc;
            end
        end
    end

    // Line receiver, sampled mid-bit on the falling edge.
    int         rx_cnt = 0;
    logic [7:0] rx_sh = 8'h00;
    logic [7:0] rx_q[$];
    logic [7:0] exp_q[$];

    always @(negedge clk) begin
        if (rx_cnt == 0) begin
            if (line == 1'b0) rx_cnt <= 1;
        end else if (rx_cnt <= 8) begin
            rx_sh[rx_cnt-1] <= line;
            rx_cnt <= rx_cnt + 1;
        end else begin
            chk("stop_bit", line, 1);
            rx_q.push_back(rx_sh);
            rx_cnt <= 0;
        end
    end

    // Requester driver: each requester presents the head of its queue until accepted.
    logic [8:0]   q [N][$];
    logic [N-1:0] hold = '0;
    int           acc_cnt [N];
    int           acc_t[$];

    initial begin
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        for (int i = 0; i < N; i++) acc_cnt[i] = 0;
        forever begin
            @(posedge clk);
            for (int i = 0; i < N; i++) begin
                if (rst_n === 1'b1 && req_valid[i] && req_ready[i] === 1'b1) begin
                    void'(q[i].pop_front());
                    acc_cnt[i]++;
                    acc_t.push_back(cyc);
                end
            end
            #1;
            for (int i = 0; i < N; i++) begin
                if (q[i].size() > 0 && !hold[i]) begin
                    req_valid[i]       = 1'b1;
                    req_data[8*i +: 8] = q[i][0][7:0];
                    req_last[i]        = q[i][0][8];
                end else begin
                    req_valid[i]       = 1'b0;
                    req_data[8*i +: 8] = 8'h00;
                    req_last[i]        = 1'b0;
                end
            end
        end
    end

    // Arbiter model: a transfer opens a 13-cycle busy window (valid/en for its first
    // two cycles); lock and pointer follow the message rules.
    bit             m_ok = 1'b0;
    int             m_cnt = 0;
    bit             m_lock = 1'b0;
    int             m_owner = 0;
    int             m_ptr = 0;
    logic [7:0]     m_txin = 8'h00;
    logic [N-1:0]   m_grant = '0;

    function automatic int winner(input logic [N-1:0] v);
        if (m_lock) return v[m_owner] ? m_owner : -1;
        for (int k = 0; k < N; k++) begin
            if (v[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    initial begin
        int           w;
        logic [N-1:0] exp_rdy;
        forever begin
            @(posedge clk);
            if (rst_n === 1'b0) begin
                m_ok = 1'b1; m_cnt = 0; m_lock = 1'b0; m_owner = 0; m_ptr = 0;
                m_txin = 8'h00; m_grant = '0;
            end else if (m_ok) begin
                w = winner(req_valid);
                if (m_cnt == 0 && en && tx_ready && w >= 0) begin
                    m_txin  = req_data[8*w +: 8];
                    m_grant = N'(1) << w;
                    m_cnt   = 13;
                    if (req_last[w]) begin
                        m_lock = 1'b0;
                        m_ptr  = (w + 1) % N;
                    end else begin
                        m_lock  = 1'b1;
                        m_owner = w;
                    end
                end else if (m_cnt > 0) begin
                    m_cnt--;
                    if (m_cnt == 0 && !m_lock) m_grant = '0;
                end
            end
            @(negedge clk);
            if (m_ok) begin
                w = winner(req_valid);
                exp_rdy = (m_cnt == 0 && en && tx_ready && w >= 0) ? N'(1) << w : '0;
                chk("req_ready", req_ready, exp_rdy);
                chk("tx_valid", tx_valid, m_cnt >= 12);
                chk("tx_en", tx_en, m_cnt >= 12);
                chk("tx_in", tx_in, m_txin);
                chk("grant", grant, m_grant);
                chk("busy", busy, (m_cnt > 0) || m_lock);
            end
        end
    end

    function automatic bit all_empty();
        for (int i = 0; i < N; i++) if (q[i].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic clear_logs();
        acc_t.delete();
        rx_q.delete();
        for (int i = 0; i < N; i++) acc_cnt[i] = 0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic set_en(input logic v);
        @(posedge clk); #1 en = v;
    endtask

    task automatic wait_acc(input int i, input int n, input string name);
        int c;
        c = 0;
        while (acc_cnt[i] < n && c < 200) begin
            @(negedge clk);
            c++;
        end
        chk(name, acc_cnt[i] >= n, 1);
    endtask

    task automatic wait_idle(input string name);
        int c;
        c = 0;
        while (!(all_empty() && busy === 1'b0 && tx_ready && tx_cnt == 0 && rx_cnt == 0)
               && c < 600) begin
            @(negedge clk);
            c++;
        end
        chk(name, c < 600, 1);
    endtask

    task automatic check_rx(input string name);
        chk({name, "_count"}, rx_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) chk(name, rx_q[i], exp_q[i]);
        rx_q.delete();
    endtask

    initial begin
        int bad;
        rst_n = 1'b0;
        en    = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_grant", grant, 0);
        chk("rst_busy", busy, 0);
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_tx_en", tx_en, 0);
        chk("rst_tx_in", tx_in, 0);
        chk("rst_req_ready", req_ready, 0);

        // Single byte 0xA5 from requester 0
        q[0].push_back({1'b1, 8'hA5});
        wait_acc(0, 1, "t1_accept");
        repeat (5) @(negedge clk);
        chk("t1_grant_mid", grant, 4'b0001);
        wait_idle("t1_idle");
        chk("t1_grant_after", grant, 0);
        chk("t1_ready_pulses", acc_cnt[0], 1);
        exp_q = {8'hA5};
        check_rx("t1_line");

        // All four requesters, round-robin order and 14-cycle spacing
        do_reset();
        clear_logs();
        for (int i = 0; i < N; i++) q[i].push_back({1'b1, 8'(8'h10 + i)});
        q[0].push_back({1'b1, 8'h10});
        wait_idle("t2_idle");
        exp_q = {8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
        check_rx("t2_order");
        chk("t2_transfers", acc_t.size(), 5);
        for (int i = 1; i < acc_t.size(); i++) chk("t2_spacing", acc_t[i] - acc_t[i-1], 14);

        // Two-byte locked message from requester 2 while requester 1 waits
        do_reset();
        clear_logs();
        q[2].push_back({1'b0, 8'h41});
        q[2].push_back({1'b1, 8'h42});
        wait_acc(2, 1, "t3_accept");
        q[1].push_back({1'b1, 8'h55});
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (grant !== 4'b0100) bad++;
        end
        chk("t3_grant_locked", bad, 0);
        wait_idle("t3_idle");
        exp_q = {8'h41, 8'h42, 8'h55};
        check_rx("t3_line");

        // Locked requester 3 goes quiet for 50 cycles
        do_reset();
        clear_logs();
        q[3].push_back({1'b0, 8'h31});
        wait_acc(3, 1, "t4_accept");
        hold[3] = 1'b1;
        q[3].push_back({1'b1, 8'h32});
        q[0].push_back({1'b1, 8'h01});
        bad = 0;
        repeat (50) begin
            @(negedge clk);
            if (busy !== 1'b1) bad++;
        end
        chk("t4_busy_stall", bad, 0);
        chk("t4_no_other_grant", acc_cnt[0], 0);
        hold[3] = 1'b0;
        wait_idle("t4_idle");
        exp_q = {8'h31, 8'h32, 8'h01};
        check_rx("t4_line");

        // en dropped mid-frame
        clear_logs();
        q[1].push_back({1'b1, 8'h61});
        wait_acc(1, 1, "t5_accept");
        repeat (4) @(negedge clk);
        set_en(1'b0);
        q[2].push_back({1'b1, 8'h62});
        bad = 0;
        repeat (30) begin
            @(negedge clk);
            if (req_ready !== 4'b0000) bad++;
        end
        chk("t5_ready_low", bad, 0);
        chk("t5_no_accept", acc_cnt[2], 0);
        exp_q = {8'h61};
        check_rx("t5_frame_done");
        set_en(1'b1);
        wait_idle("t5_idle");
        exp_q = {8'h62};
        check_rx("t5_resume");

        // Reset during the third data bit
        clear_logs();
        q[0].push_back({1'b1, 8'hC3});
        wait_acc(0, 1, "t6_accept");
        q[1].push_back({1'b1, 8'h77});
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("t6_grant", grant, 0);
        chk("t6_busy", busy, 0);
        chk("t6_tx_valid", tx_valid, 0);
        chk("t6_tx_en", tx_en, 0);
        chk("t6_tx_in", tx_in, 0);
        chk("t6_req_ready", req_ready, 0);
        wait_acc(1, 1, "t6_accept_after");
        chk("t6_ready_after_txready", acc_t[acc_t.size()-1] - t_rdy, 1);
        wait_idle("t6_idle");
        exp_q = {8'hC3, 8'h77};
        check_rx("t6_line");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "timeout");
    end

endmodule
